// File: rtl/alu_pipe_if.sv
// Operation/result channel between decode and writeback for alu_pipe.
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    // A beat moves on a channel only in a cycle where valid && ready; the sender
    // holds its payload stable from raising valid until that cycle.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             ovfl;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, ctrl, out_ready,
        input  in_ready, out_valid, out, ovfl, zero, neg
    );

    modport slave (
        input  in_valid, a, b, ctrl, out_ready,
        output in_ready, out_valid, out, ovfl, zero, neg
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, saturating add/sub and an
// iterative shift-add unsigned multiply (one product bit per cycle).
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_pipe_if.slave   bus,
    output logic [1:0]  dbg_state
);
    localparam int SHW = $clog2(WIDTH);
    localparam int H   = WIDTH / 2;
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

    state_t             state, state_next;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] ma, acc, acc_step;
    logic [WIDTH-1:0]   mb;
    logic               out_valid_q, ovfl_q, zero_q, neg_q;
    logic [WIDTH-1:0]   out_q;

    logic               free, accept, load, load_ovf;
    logic [WIDTH-1:0]   load_res, alu_res, sum, diff;
    logic               alu_ovf, add_ovf, sub_ovf;

    assign free          = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = (state == IDLE) && free;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.ovfl      = ovfl_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign dbg_state     = state;

    assign acc_step = acc + (mb[0] ? ma : '0);

    always_comb begin
        sum     = bus.a + bus.b;
        diff    = bus.a - bus.b;
        add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        // Operands of differing sign: a-b overflows when the sign flips away from a.
        sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.ctrl)
            5'h00, 5'h0A, 5'h0B: begin alu_res = sum;  alu_ovf = add_ovf; end
            5'h01:               begin alu_res = diff; alu_ovf = sub_ovf; end
            5'h02: alu_res = bus.a & bus.b;
            5'h03: alu_res = bus.a | bus.b;
            5'h04: alu_res = bus.a ^ bus.b;
            5'h05: alu_res = bus.a << bus.b[SHW-1:0];
            5'h06: alu_res = $signed(bus.a) >>> bus.b[SHW-1:0];
            5'h08: alu_res = {bus.a[WIDTH-1:H], bus.b[H-1:0]};
            5'h09: alu_res = {bus.b[H-1:0], bus.a[H-1:0]};
            5'h0C: begin
                alu_res = add_ovf ? (bus.a[WIDTH-1] ? SAT_MIN : SAT_MAX) : sum;
                alu_ovf = add_ovf;
            end
            5'h0D: begin
                alu_res = sub_ovf ? (bus.a[WIDTH-1] ? SAT_MIN : SAT_MAX) : diff;
                alu_ovf = sub_ovf;
            end
            default: begin alu_res = '0; alu_ovf = 1'b0; end
        endcase
    end

    // The last multiply iteration writes the product straight out when the
    // output register is free; DONE only absorbs backpressure.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_res   = '0;
        load_ovf   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.ctrl == 5'h07) begin
                        state_next = MUL;
                    end else begin
                        load     = 1'b1;
                        load_res = alu_res;
                        load_ovf = alu_ovf;
                    end
                end
            end
            MUL: begin
                if (cnt == LAST) begin
                    if (free) begin
                        load       = 1'b1;
                        load_res   = acc_step[WIDTH-1:0];
                        load_ovf   = |acc_step[2*WIDTH-1:WIDTH];
                        state_next = IDLE;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (free) begin
                    load       = 1'b1;
                    load_res   = acc[WIDTH-1:0];
                    load_ovf   = |acc[2*WIDTH-1:WIDTH];
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ma  <= '0;
            mb  <= '0;
            acc <= '0;
        end else if (state == IDLE && accept && bus.ctrl == 5'h07) begin
            cnt <= '0;
            ma  <= {{WIDTH{1'b0}}, bus.a};
            mb  <= bus.b;
            acc <= '0;
        end else if (state == MUL) begin
            acc <= acc_step;
            ma  <= ma << 1;
            mb  <= mb >> 1;
            cnt <= (cnt == LAST) ? '0 : cnt + SHW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ovfl_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_q       <= load_res;
            ovfl_q      <= load_ovf;
            zero_q      <= (load_res == '0);
            neg_q       <= load_res[WIDTH-1];
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule
